// File: rtl/npc_imm_pkg.sv
// Shared definitions for the NPC decode-stage immediate generator.
// Format-select codes for the ext_op field.
package npc_imm_pkg;

    typedef logic [2:0] ext_op_t;

    localparam ext_op_t EXT_I   = 3'd0;
    localparam ext_op_t EXT_U   = 3'd1;
    localparam ext_op_t EXT_S   = 3'd2;
    localparam ext_op_t EXT_B   = 3'd3;
    localparam ext_op_t EXT_J   = 3'd4;
    localparam ext_op_t EXT_Z   = 3'd5;
    localparam ext_op_t EXT_SH  = 3'd6;
    localparam ext_op_t EXT_ILL = 3'd7;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle between decode and the immediate generator, both sides.
// The slave modport is the generator; the master modport is its environment.
interface imm_gen_pipe_if
    import npc_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    ext_op_t          in_ext_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_inst, in_ext_op, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_inst, in_ext_op, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate decode for the RV I/U/S/B/J formats plus CSR-zimm
// and shift-amount; flags the reserved format code as illegal.
module imm_decode
    import npc_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst_i,
    input  ext_op_t         ext_op_i,
    output logic [XLEN-1:0] imm_o,
    output logic            err_o
);
    logic [31:0] imm32;
    logic        sext;
    logic        s;

    assign s = inst_i[31];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        imm32 = '0;
        sext  = 1'b1;
        err_o = 1'b0;
        case (ext_op_i)
            EXT_I:  imm32 = {{20{s}}, inst_i[31:20]};
            EXT_U:  imm32 = {inst_i[31:12], 12'b0};
            EXT_S:  imm32 = {{20{s}}, inst_i[31:25], inst_i[11:7]};
            EXT_B:  imm32 = {{20{s}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            EXT_J:  imm32 = {{12{s}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            EXT_Z: begin
                imm32 = {27'b0, inst_i[19:15]};
                sext  = 1'b0;
            end
            EXT_SH: begin
                // RV64 shifts take a 6-bit shamt; RV32 ignores inst[25].
                imm32 = (XLEN == 64) ? {26'b0, inst_i[25:20]} : {27'b0, inst_i[24:20]};
                sext  = 1'b0;
            end
            default: begin
                imm32 = '0;
                err_o = 1'b1;
            end
        endcase

        if (sext) begin
            imm_o = XLEN'($signed(imm32));
        end else begin
            imm_o = XLEN'(imm32);
        end
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode on the input side, one output
// register plus a one-entry skid so back-pressure never drops an instruction.
module imm_gen_pipe
    import npc_imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    imm_gen_pipe_if.slave        bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]      dec_imm;
    logic                 dec_err;

    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      out_imm_q,   out_imm_d;
    logic [TAG_W-1:0]     out_tag_q,   out_tag_d;
    logic                 out_err_q,   out_err_d;

    logic                 skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]      skid_imm_q,   skid_imm_d;
    logic [TAG_W-1:0]     skid_tag_q,   skid_tag_d;
    logic                 skid_err_q,   skid_err_d;

    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 in_fire;
    logic                 out_free;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst_i   (bus.in_inst[31:7]),
        .ext_op_i (bus.in_ext_op),
        .imm_o    (dec_imm),
        .err_o    (dec_err)
    );

    assign bus.in_ready = ~skid_valid_q;
    assign in_fire      = bus.in_valid & ~skid_valid_q;
    assign out_free     = ~out_valid_q | bus.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        err_cnt_d    = err_cnt_q;

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_tag_d   = bus.in_tag;
                out_err_d   = dec_err;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_tag_d   = bus.in_tag;
            skid_err_d   = dec_err;
        end

        // Counted at acceptance only, so a skid replay or a held output never re-counts.
        if (in_fire && dec_err && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset too, since out_imm/out_tag must read zero after reset.
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;
    assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, directed
// vectors with hand-computed immediates, back-pressure, saturation and reset.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] err_cnt32;
    logic [7:0] err_cnt64;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt32 = 0;
    bit   done = 1'b0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ERR_CNT_W(8)) dut32 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus32),
        .err_cnt (err_cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ERR_CNT_W(8)) dut64 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus64),
        .err_cnt (err_cnt64)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic send32(input logic [31:0] inst, input logic [2:0] op, input logic [31:0] tag,
                          input logic [63:0] imm, input logic err);
        int waited = 0;
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = inst;
        bus32.in_ext_op = op;
        bus32.in_tag    = tag;
        @(negedge clk);
        while (!bus32.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus32.in_ready) begin
            check("in32_accept_timeout", 64'(bus32.in_ready), 64'd1);
        end else begin
            q32.push_back('{imm: imm, tag: tag, err: err});
            if (op == 3'd7 && exp_cnt32 != 255) exp_cnt32++;
        end
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [31:0] inst, input logic [2:0] op, input logic [31:0] tag,
                          input logic [63:0] imm, input logic err);
        int waited = 0;
        bus64.in_valid  = 1'b1;
        bus64.in_inst   = inst;
        bus64.in_ext_op = op;
        bus64.in_tag    = tag;
        @(negedge clk);
        while (!bus64.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus64.in_ready) begin
            check("in64_accept_timeout", 64'(bus64.in_ready), 64'd1);
        end else begin
            q64.push_back('{imm: imm, tag: tag, err: err});
        end
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_q32_left", 64'(q32.size()), 64'd0);
        check("drain_q64_left", 64'(q64.size()), 64'd0);
    endtask

    // Monitors: sample at the falling edge, when a handshake for the next rising edge is settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus32.out_valid && bus32.out_ready) begin
                if (q32.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out32_unexpected: got imm 0x%0h tag 0x%0h, expected no output",
                             bus32.out_imm, bus32.out_tag);
                end else begin
                    e = q32.pop_front();
                    check("out32_imm", 64'(bus32.out_imm), e.imm);
                    check("out32_tag", 64'(bus32.out_tag), 64'(e.tag));
                    check("out32_err", 64'(bus32.out_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus64.out_valid && bus64.out_ready) begin
                if (q64.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out64_unexpected: got imm 0x%0h tag 0x%0h, expected no output",
                             bus64.out_imm, bus64.out_tag);
                end else begin
                    e = q64.pop_front();
                    check("out64_imm", bus64.out_imm, e.imm);
                    check("out64_tag", 64'(bus64.out_tag), 64'(e.tag));
                    check("out64_err", 64'(bus64.out_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: got no completion, expected end of test before time limit");
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        rst             = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in_inst   = '0;
        bus32.in_ext_op = '0;
        bus32.in_tag    = '0;
        bus32.out_ready = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.in_inst   = '0;
        bus64.in_ext_op = '0;
        bus64.in_tag    = '0;
        bus64.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus32.in_ready),  64'd1);
        check("rst_out_imm",   64'(bus32.out_imm),   64'd0);
        check("rst_out_tag",   64'(bus32.out_tag),   64'd0);
        check("rst_out_err",   64'(bus32.out_err),   64'd0);
        check("rst_err_cnt",   64'(err_cnt32),       64'd0);
        check("rst64_out_valid", 64'(bus64.out_valid), 64'd0);
        check("rst64_in_ready",  64'(bus64.in_ready),  64'd1);

        // Directed XLEN=32 formats, back to back.
        bus32.out_ready = 1'b1;
        bus64.out_ready = 1'b1;
        send32(32'hFFF00093, 3'd0, 32'h0000_1000, 64'hFFFF_FFFF, 1'b0);
        send32(32'h12345037, 3'd1, 32'h0000_1004, 64'h1234_5000, 1'b0);
        send32(32'hFE112C23, 3'd2, 32'h0000_1008, 64'hFFFF_FFF8, 1'b0);
        send32(32'hFFDFF06F, 3'd4, 32'h0000_100C, 64'hFFFF_FFFC, 1'b0);
        send32(32'h000F8073, 3'd5, 32'h0000_1010, 64'h0000_001F, 1'b0);
        send32(32'h03F01013, 3'd6, 32'h0000_1014, 64'h0000_001F, 1'b0);
        send32(32'hFE000EE3, 3'd3, 32'h0000_1018, 64'hFFFF_FFFC, 1'b0);
        send32(32'h00000463, 3'd3, 32'h0000_101C, 64'h0000_0008, 1'b0);
        send32(32'h7FF00013, 3'd0, 32'h0000_1020, 64'h0000_07FF, 1'b0);
        send32(32'hFFFFFFFF, 3'd7, 32'h0000_1024, 64'h0000_0000, 1'b1);
        check("err_cnt_one", 64'(err_cnt32), 64'd1);

        // Directed XLEN=64 formats.
        send64(32'hFFF00093, 3'd0, 32'h0000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send64(32'h80000037, 3'd1, 32'h0000_2004, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send64(32'h03F01013, 3'd6, 32'h0000_2008, 64'h0000_0000_0000_003F, 1'b0);
        send64(32'hFFDFF06F, 3'd4, 32'h0000_200C, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send64(32'h000F8073, 3'd5, 32'h0000_2010, 64'h0000_0000_0000_001F, 1'b0);
        drain();
        check("err_cnt64_zero", 64'(err_cnt64), 64'd0);

        // Back-pressure: two accepted into out + skid, then the rest wait for release.
        bus32.out_ready = 1'b0;
        send32(32'h7FF00013, 3'd0, 32'h0000_0200, 64'h0000_07FF, 1'b0);
        send32(32'h00112423, 3'd2, 32'h0000_0204, 64'h0000_0008, 1'b0);
        check("bp_in_ready_low", 64'(bus32.in_ready),  64'd0);
        check("bp_out_valid",    64'(bus32.out_valid), 64'd1);
        fork
            begin
                send32(32'h00000463, 3'd3, 32'h0000_0208, 64'h0000_0008, 1'b0);
                send32(32'hFE000EE3, 3'd3, 32'h0000_020C, 64'hFFFF_FFFC, 1'b0);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold_imm",  64'(bus32.out_imm),  64'h0000_07FF);
                    check("bp_hold_tag",  64'(bus32.out_tag),  64'h0000_0200);
                    check("bp_hold_ready", 64'(bus32.in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                bus32.out_ready = 1'b1;
            end
        join
        drain();

        // Illegal format stream: counter saturates at 255 without wrapping.
        for (int i = 0; i < 300; i++) begin
            send32(32'hFFFFFFFF, 3'd7, 32'h0000_3000 + 32'(i), 64'h0, 1'b1);
            check("err_cnt_track", 64'(err_cnt32), 64'(exp_cnt32));
        end
        check("err_cnt_sat", 64'(err_cnt32), 64'd255);
        drain();

        // Reset while both out and skid hold entries.
        bus32.out_ready = 1'b0;
        send32(32'hFFF00093, 3'd0, 32'h0000_0400, 64'hFFFF_FFFF, 1'b0);
        send32(32'hFFFFFFFF, 3'd7, 32'h0000_0404, 64'h0,         1'b1);
        check("pre_rst_skid_full", 64'(bus32.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q32.delete();
        exp_cnt32 = 0;
        check("mid_rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(bus32.in_ready),  64'd1);
        check("mid_rst_err_cnt",   64'(err_cnt32),       64'd0);
        check("mid_rst_out_imm",   64'(bus32.out_imm),   64'd0);

        bus32.out_ready = 1'b1;
        send32(32'hFFDFF06F, 3'd4, 32'h0000_0500, 64'hFFFF_FFFC, 1'b0);
        check("post_rst_latency_valid", 64'(bus32.out_valid), 64'd1);
        check("post_rst_latency_imm",   64'(bus32.out_imm),   64'hFFFF_FFFC);
        drain();

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the NPC decode stage. It replaces the single-cycle, RV32-only, five-format immediate mux. It adds XLEN 32/64 support, CSR-zimm and shift-amount formats, and illegal-format detection. It sits between instruction fetch/decode and the register-read/execute boundary, with a valid/ready handshake on both sides and a one-entry skid buffer, so back-pressure never drops an instruction.

Parameters:
XLEN, 32, datapath width; only 32 or 64 are legal, and any other value is an elaboration error.
TAG_W, 32, width of the opaque sideband (normally the PC) carried alongside the immediate.
ERR_CNT_W, 8, width of the saturating illegal-format counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  upstream has an instruction.
in_ready  out  1  block can accept this cycle.
in_inst  in  32  raw instruction; bits [31:7] are used.
in_ext_op  in  3  format select: 0=I, 1=U, 2=S, 3=B, 4=J, 5=Z, 6=SH, 7=illegal.
in_tag  in  TAG_W  sideband, passed through unchanged.
out_valid  out  1  immediate available.
out_ready  in  1  downstream accepts.
out_imm  out  XLEN  generated immediate.
out_tag  out  TAG_W  sideband matching out_imm.
out_err  out  1  accompanying instruction had ext_op=7.
err_cnt  out  ERR_CNT_W  accepted illegal-format count.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, skid empty, in_ready=1 after the edge.
  - out_imm=0, out_tag=0, out_err=0, err_cnt=0.
  - Reset mid-transfer discards the output register and the skid entry. No handshake completes on a reset cycle.
- Handshakes:
  - An input transfer happens when in_valid&in_ready.
  - An output transfer happens when out_valid&out_ready.
  - in_valid and in_ready are independent. No combinational path from out_ready to in_ready: in_ready = ~skid_valid, which is registered.
  - out_imm, out_tag and out_err stay stable while out_valid=1 and out_ready=0.
- Latency and throughput: 1 cycle from input transfer to out_valid. Sustained 1 transfer per cycle when out_ready=1.
- Output register update, each cycle:
  - If out register is empty or an output transfer occurs:
    - If skid is valid, move skid into out and clear skid.
    - Else, if an input transfer occurs, load the decoded input into out.
    - Else, clear out_valid.
  - If out is held (valid and not ready) and an input transfer occurs, capture the decoded input into skid.
  - Simultaneous output transfer and input transfer while skid is valid cannot occur, because in_ready=0.
- Immediate formats (s = inst[31], sign-extended to XLEN):
  - I: sext(inst[31:20]).
  - U: sext({inst[31:12], 12'b0}); on XLEN=64, bit 31 is replicated into [63:32].
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Z: zero-extended inst[19:15] (CSR uimm).
  - SH: zero-extended inst[24:20] when XLEN=32; zero-extended inst[25:20] when XLEN=64.
  - 7: out_imm=0, out_err=1. All other formats produce out_err=0.
- Error counter: increments by 1 on each accepted input with ext_op=7. It saturates at all-ones with no wrap. A held output or a skid replay does not re-count.

Decomposition:
- Shared package npc_imm_pkg:
  - localparam codes EXT_I, EXT_U, EXT_S, EXT_B, EXT_J, EXT_Z, EXT_SH, EXT_ILL (3 bits).
  - The ext_op typedef.
- Combinational sub-module imm_decode (parameter XLEN):
  - Inputs inst[31:7] and ext_op; outputs imm and err.
  - Instantiated once, on the input side, so the skid stores decoded values.
- The top level holds the output register, the skid register and the counter.

Test Plan:
- Reset, then with XLEN=32 and out_ready=1, send I 0xFFF00093, U 0x12345037, S 0xFE112C23 on consecutive cycles -> one cycle later each: 0xFFFFFFFF, 0x12345000, 0xFFFFFFF8, with tags preserved.
- J 0xFFDFF06F -> 0xFFFFFFFC. Z with inst[19:15]=0x1F -> 0x0000001F. SH with inst[25:20]=0x3F: XLEN=32 -> 0x1F, XLEN=64 -> 0x3F.
- XLEN=64: I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF. U 0x80000037 -> 0xFFFFFFFF80000000.
- Back-pressure: stream 4 instructions with out_ready=0 for 3 cycles -> in_ready drops after the 2nd transfer; output held stable; after release, all 4 emerge in order, none lost or duplicated.
- ext_op=7 sent 300 times with ERR_CNT_W=8 -> out_imm=0 and out_err=1 each time; err_cnt saturates at 255.
- Assert rst while out and skid are both valid -> next cycle out_valid=0, in_ready=1, err_cnt=0; a fresh input then yields a correct result 1 cycle later.
